spi_reg_bridge: RTL and testbench

SPI slave front-end that turns two-byte host frames into the single-cycle `address`/`write_en`/`wr_data`/`read_en` strobes consumed by `reg_file`, and returns `rd_data` to the host on MISO. It sits directly upstream of `reg_file` in the subsystem. It oversamples the host SPI pins (mode 0, MSB first) on the system clock; no logic runs in the SCLK domain.

---
 rtl/spi_reg_bridge_pkg.sv | 31 +++
 rtl/spi_reg_bridge_sync_edge.sv | 38 +++
 rtl/spi_reg_bridge.sv | 207 ++++++++++++++++++++
 tb/tb_spi_reg_bridge.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_bridge_pkg.sv
// spi_bridge_pkg: shared types and constants for the SPI register bridge.
//   state_e        frame-level FSM states
//   RW_BIT         command-byte bit selecting read (1) or write (0)
//   FRAME_BITS     SCLK rises in a complete frame (command + data byte)
//   CNT_W          width of the SCLK rise counter
//   abortable()    states in which a CS_n deassertion aborts the frame
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_REQ,
    ST_RD_LOAD,
    ST_RDATA,
    ST_WDATA,
    ST_WR,
    ST_DONE
  } state_e;

  localparam int RW_BIT     = 7;
  localparam int FRAME_BITS = 16;
  localparam int CNT_W      = $clog2(FRAME_BITS + 1);

  // WR and DONE are past the point of no return: the frame has already
  // been fully received, so a CS_n rise there is a normal frame end.
  function automatic logic abortable(input state_e s);
    return (s == ST_CMD) || (s == ST_WDATA) || (s == ST_RD_REQ) ||
           (s == ST_RD_LOAD) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/spi_reg_bridge_sync_edge.sv
// sync_edge: two-flop synchroniser for an asynchronous pin plus a history
// flop for single-cycle edge detection in the system clock domain.
//   clk_i   system clock
//   rst_ni  synchronous active-low reset (all flops clear to 0)
//   d_i     asynchronous input pin
//   q_o     synchronised level
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q, sync_q, hist_q;

  // Clearing to 0 matters for CS_n: a stale 1 after reset would look like
  // an idle bus and re-arm the bridge in the middle of a host frame.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      hist_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~hist_q;
  assign fall_o = ~sync_q & hist_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI mode-0 slave (MSB first) that decodes two-byte host
// frames into single-cycle register strobes for reg_file. The SPI pins are
// oversampled on the system clock; nothing runs on SCLK.
//   clock, reset_n   system clock, synchronous active-low reset
//   spi_sclk/cs_n/mosi  asynchronous host pins; spi_miso slave data out
//   address, wr_data held register address / write data
//   write_en, read_en   one-cycle strobes toward reg_file
//   rd_data             reg_file read data, valid the cycle after read_en
//   frame_err           one-cycle pulse when a frame is aborted
// Frame: byte 0 = {R/W, reserved, addr[5:0]}; byte 1 = write data on MOSI
// or read data on MISO.
module spi_reg_bridge
  import spi_bridge_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              spi_sclk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic              write_en,
  output logic [DATA_W-1:0] wr_data,
  output logic              read_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic              frame_err
);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;

  sync_edge u_sclk_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (spi_sclk),
    .q_o    (sclk_lvl),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge u_cs_sync (
    .clk_i  (clock),
    .rst_ni (reset_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_lvl),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Framing works from the CS_n level; its edges are not needed.
  logic unused_sync;
  assign unused_sync = sclk_lvl ^ cs_rise ^ cs_fall;

  // MOSI only needs the synchroniser; it is sampled on SCLK rise detects,
  // which share the same two-flop latency.
  logic mosi_meta_q, mosi_sync_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mosi_meta_q <= 1'b0;
      mosi_sync_q <= 1'b0;
    end else begin
      mosi_meta_q <= spi_mosi;
      mosi_sync_q <= mosi_meta_q;
    end
  end

  state_e            state_q;
  logic              armed_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sh_q;
  logic [DATA_W-1:0] miso_sh_q;
  logic [ADDR_W-1:0] address_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              write_en_q, read_en_q, miso_q, frame_err_q;

  // Byte value including the bit arriving on this SCLK rise.
  logic [DATA_W-1:0] byte_d;
  assign byte_d = {sh_q[DATA_W-2:0], mosi_sync_q};

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      armed_q     <= 1'b0;
      cnt_q       <= '0;
      sh_q        <= '0;
      miso_sh_q   <= '0;
      address_q   <= '0;
      wr_data_q   <= '0;
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      frame_err_q <= 1'b0;

      // Only an observed idle bus arms the bridge, so a reset released
      // with CS_n low never picks up the tail of the interrupted frame.
      if (cs_lvl) armed_q <= 1'b1;

      // Abort takes priority over a same-cycle SCLK rise, so a CS_n rise
      // coinciding with the 16th rise still suppresses the write.
      if (cs_lvl && abortable(state_q)) begin
        state_q     <= ST_IDLE;
        frame_err_q <= 1'b1;
        miso_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            miso_q <= 1'b0;
            if (armed_q && !cs_lvl) begin
              state_q <= ST_CMD;
              cnt_q   <= '0;
              sh_q    <= '0;
            end
          end

          ST_CMD: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              sh_q  <= byte_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(DATA_W - 1)) begin
                address_q <= byte_d[ADDR_W-1:0];
                // read_en is set on the transition so it is high during
                // RD_REQ, one cycle after the 8th rise is detected.
                if (byte_d[RW_BIT]) begin
                  state_q   <= ST_RD_REQ;
                  read_en_q <= 1'b1;
                end else begin
                  state_q <= ST_WDATA;
                end
              end
            end
          end

          ST_RD_REQ: begin
            miso_q  <= 1'b0;
            state_q <= ST_RD_LOAD;
          end

          ST_RD_LOAD: begin
            miso_sh_q <= rd_data;
            miso_q    <= rd_data[DATA_W-1];
            state_q   <= ST_RDATA;
          end

          ST_RDATA: begin
            if (sclk_rise) begin
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                state_q <= ST_DONE;
                miso_q  <= 1'b0;
              end
            end else if (sclk_fall && (cnt_q > CNT_W'(DATA_W))) begin
              // The MSB was driven at load time and must survive the fall
              // right after the 8th rise; only later falls advance MISO.
              miso_sh_q <= {miso_sh_q[DATA_W-2:0], 1'b0};
              miso_q    <= miso_sh_q[DATA_W-2];
            end
          end

          ST_WDATA: begin
            miso_q <= 1'b0;
            if (sclk_rise) begin
              sh_q  <= byte_d;
              cnt_q <= cnt_q + CNT_W'(1);
              if (cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                wr_data_q  <= byte_d;
                write_en_q <= 1'b1;
                state_q    <= ST_WR;
              end
            end
          end

          ST_WR: begin
            miso_q  <= 1'b0;
            state_q <= ST_DONE;
          end

          ST_DONE: begin
            miso_q <= 1'b0;
            if (cs_lvl) state_q <= ST_IDLE;
          end

          default: begin
            miso_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign spi_miso  = miso_q;
  assign address   = address_q;
  assign write_en  = write_en_q;
  assign wr_data   = wr_data_q;
  assign read_en   = read_en_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Self-checking bench for spi_reg_bridge: directed frames from the test
// plan plus randomized frames compared against a frame-level model.
module tb_spi_reg_bridge;

  localparam int HALF = 8;  // SCLK half-period in system clocks

  logic       clock = 1'b0;
  logic       reset_n, spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic       write_en, read_en, frame_err;
  logic [5:0] address;
  logic [7:0] wr_data, rd_data;

  spi_reg_bridge #(.ADDR_W(6), .DATA_W(8)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .spi_sclk  (spi_sclk),
    .spi_cs_n  (spi_cs_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .address   (address),
    .write_en  (write_en),
    .wr_data   (wr_data),
    .read_en   (read_en),
    .rd_data   (rd_data),
    .frame_err (frame_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int gap = 10;

  // Observed strobes
  logic [13:0] wr_log[$];
  logic [5:0]  rd_log[$];
  bit          ev_log[$];  // 0 = read, 1 = write, in order of occurrence
  int          err_cnt, both_cnt;
  logic [7:0]  rd_resp;
  bit          rd_hold;
  logic [31:0] miso_seen;

  // Model of the held registers
  logic [5:0]  addr_m;
  logic [7:0]  wd_m;

  typedef struct {
    int n_wr;
    int n_rd;
    int n_err;
  } exp_t;

  // reg_file stand-in: rd_data is only correct on the cycle after read_en.
  always @(negedge clock) begin
    if (write_en) begin wr_log.push_back({address, wr_data}); ev_log.push_back(1'b1); end
    if (read_en)  begin rd_log.push_back(address); ev_log.push_back(1'b0); end
    if (frame_err) err_cnt++;
    if (write_en && read_en) both_cnt++;
    if (read_en) begin rd_data = rd_resp; rd_hold = 1'b1; end
    else if (rd_hold) rd_hold = 1'b0;
    else rd_data = ~rd_resp;
  end

  // Frame outcome from the protocol rules: the command byte is complete
  // after 8 bits, the frame after 16; anything shorter is an abort.
  function automatic exp_t model_frame(input logic [7:0] cmd, input logic [7:0] data,
                                       input int nbits);
    exp_t e;
    e.n_wr  = 0;
    e.n_rd  = 0;
    e.n_err = (nbits < 16) ? 1 : 0;
    if (nbits >= 8) begin
      addr_m = cmd[5:0];
      e.n_rd = cmd[7] ? 1 : 0;
    end
    if (nbits >= 16 && !cmd[7]) begin
      e.n_wr = 1;
      wd_m   = data;
    end
    return e;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clear_logs();
    wr_log.delete(); rd_log.delete(); ev_log.delete();
    err_cnt = 0; both_cnt = 0;
  endtask

  // Host side of one frame. rst_at: pulse reset after that bit (-1 none).
  // cs_on_last: raise CS_n together with the last SCLK rise.
  task automatic drive_frame(input logic [15:0] fr, input int nbits, input int rst_at,
                             input bit cs_on_last);
    miso_seen = '0;
    spi_cs_n = 1'b0;
    wait_clk(4);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = (i < 16) ? fr[15-i] : 1'($urandom_range(0, 1));
      wait_clk(HALF);
      miso_seen[i] = spi_miso;
      spi_sclk = 1'b1;
      if (cs_on_last && i == nbits - 1) spi_cs_n = 1'b1;
      wait_clk(HALF);
      spi_sclk = 1'b0;
      if (i == rst_at) begin
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
      end
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(4);
    checks++;
    if ({address, wr_data} !== 14'h0) begin
      errors++; $display("FAIL reset_regs got addr=%h wdata=%h exp 0/0", address, wr_data);
    end
    checks++;
    if ({write_en, read_en, spi_miso, frame_err} !== 4'b0) begin
      errors++; $display("FAIL reset_strobes got we=%b re=%b miso=%b err=%b exp 0", write_en,
                         read_en, spi_miso, frame_err);
    end
    reset_n = 1'b1;
    wait_clk(gap);
  endtask

  task automatic test_write();
    exp_t e;
    logic [13:0] got;
    clear_logs();
    e = model_frame(8'h0C, 8'hA5, 16);
    drive_frame(16'h0CA5, 16, -1, 1'b0);
    got = (wr_log.size() > 0) ? wr_log[0] : 14'h0;
    checks++;
    if (wr_log.size() != e.n_wr || got !== {6'h0C, 8'hA5}) begin
      errors++; $display("FAIL write_basic got n=%0d val=%h exp n=1 val=%h", wr_log.size(), got,
                         {6'h0C, 8'hA5});
    end
    checks++;
    if (rd_log.size() != 0 || miso_seen !== 32'h0) begin
      errors++; $display("FAIL write_quiet got reads=%0d miso=%h exp 0/0", rd_log.size(), miso_seen);
    end
  endtask

  task automatic test_read();
    exp_t e;
    logic [7:0] got;
    clear_logs();
    rd_resp = 8'h3C;
    e = model_frame(8'h8F, 8'h00, 16);
    drive_frame(16'h8F00, 16, -1, 1'b0);
    for (int k = 0; k < 8; k++) got[7-k] = miso_seen[8+k];
    checks++;
    if (rd_log.size() != e.n_rd || (rd_log.size() > 0 && rd_log[0] !== 6'h0F)) begin
      errors++; $display("FAIL read_strobe got n=%0d exp n=1 addr=0f", rd_log.size());
    end
    checks++;
    if (got !== 8'h3C || miso_seen[7:0] !== 8'h0) begin
      errors++; $display("FAIL read_miso got %h (cmd bits %h) exp 3c (00)", got, miso_seen[7:0]);
    end
    checks++;
    if (wr_log.size() != 0 || err_cnt != 0) begin
      errors++; $display("FAIL read_side got writes=%0d errs=%0d exp 0/0", wr_log.size(), err_cnt);
    end
  endtask

  task automatic test_abort();
    exp_t e;
    clear_logs();
    e = model_frame(8'h15, 8'h77, 11);
    drive_frame(16'h1577, 11, -1, 1'b0);
    checks++;
    if (wr_log.size() != 0 || err_cnt != e.n_err) begin
      errors++; $display("FAIL abort11 got writes=%0d errs=%0d exp 0/1", wr_log.size(), err_cnt);
    end
    checks++;
    if (address !== addr_m || wr_data !== wd_m) begin
      errors++; $display("FAIL abort_hold got %h/%h exp %h/%h", address, wr_data, addr_m, wd_m);
    end
    clear_logs();
    e = model_frame(8'h38, 8'h1F, 16);
    drive_frame(16'h381F, 16, -1, 1'b0);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {6'h38, 8'h1F} || err_cnt != 0) begin
      errors++; $display("FAIL after_abort got writes=%0d errs=%0d exp one write 38/1f", wr_log.size(),
                         err_cnt);
    end
  endtask

  task automatic test_abort_on_16th();
    exp_t e;
    clear_logs();
    e = model_frame(8'h2C, 8'h11, 15);
    drive_frame(16'h2C11, 16, -1, 1'b1);
    checks++;
    if (wr_log.size() != 0 || err_cnt != e.n_err || wr_data !== wd_m) begin
      errors++; $display("FAIL abort16 got writes=%0d errs=%0d wdata=%h exp 0/1/%h", wr_log.size(),
                         err_cnt, wr_data, wd_m);
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_logs();
    drive_frame(16'h2A66, 16, 4, 1'b0);
    addr_m = 6'h0;
    wd_m = 8'h0;
    checks++;
    if (wr_log.size() != 0 || rd_log.size() != 0 || err_cnt != 0) begin
      errors++; $display("FAIL rst_mid got writes=%0d reads=%0d errs=%0d exp 0", wr_log.size(),
                         rd_log.size(), err_cnt);
    end
    checks++;
    if (address !== 6'h0 || wr_data !== 8'h0) begin
      errors++; $display("FAIL rst_mid_regs got %h/%h exp 0/0", address, wr_data);
    end
    clear_logs();
    void'(model_frame(8'h13, 8'h96, 16));
    drive_frame(16'h1396, 16, -1, 1'b0);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {6'h13, 8'h96}) begin
      errors++; $display("FAIL rst_next got n=%0d exp one write 13/96", wr_log.size());
    end
  endtask

  task automatic test_extra_sclk();
    clear_logs();
    void'(model_frame(8'h04, 8'hFF, 20));
    drive_frame(16'h04FF, 20, -1, 1'b0);
    checks++;
    if (wr_log.size() != 1 || wr_log[0] !== {6'h04, 8'hFF} || err_cnt != 0) begin
      errors++; $display("FAIL extra_sclk got writes=%0d errs=%0d exp one write 04/ff", wr_log.size(),
                         err_cnt);
    end
    checks++;
    if (miso_seen !== 32'h0) begin
      errors++; $display("FAIL extra_miso got %h exp 0", miso_seen);
    end
  endtask

  task automatic test_back_to_back();
    clear_logs();
    rd_resp = 8'($urandom);
    void'(model_frame(8'hA0, 8'h00, 16));
    void'(model_frame(8'h21, 8'h5A, 16));
    gap = 4;
    drive_frame(16'hA000, 16, -1, 1'b0);
    gap = 10;
    drive_frame(16'h215A, 16, -1, 1'b0);
    checks++;
    if (ev_log.size() != 2 || ev_log[0] != 1'b0 || ev_log[1] != 1'b1) begin
      errors++; $display("FAIL b2b_order got %0d events exp read then write", ev_log.size());
    end
    checks++;
    if (rd_log.size() != 1 || rd_log[0] !== 6'h20 || wr_log.size() != 1 ||
        wr_log[0] !== {6'h21, 8'h5A}) begin
      errors++; $display("FAIL b2b_values got reads=%0d writes=%0d exp rd 20, wr 21/5a",
                         rd_log.size(), wr_log.size());
    end
    checks++;
    if (both_cnt != 0 || err_cnt != 0) begin
      errors++; $display("FAIL b2b_side got both=%0d errs=%0d exp 0/0", both_cnt, err_cnt);
    end
  endtask

  task automatic test_random();
    exp_t e;
    logic [7:0] cmd, data, got;
    int nbits;
    for (int f = 0; f < 12; f++) begin
      cmd = 8'($urandom);
      data = 8'($urandom);
      rd_resp = 8'($urandom);
      nbits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      e = model_frame(cmd, data, nbits);
      clear_logs();
      drive_frame({cmd, data}, nbits, -1, 1'b0);
      checks++;
      if (wr_log.size() != e.n_wr || rd_log.size() != e.n_rd || err_cnt != e.n_err) begin
        errors++; $display("FAIL rnd%0d_counts cmd=%h n=%0d got w=%0d r=%0d e=%0d exp %0d/%0d/%0d",
                           f, cmd, nbits, wr_log.size(), rd_log.size(), err_cnt, e.n_wr, e.n_rd,
                           e.n_err);
      end
      checks++;
      if (address !== addr_m || wr_data !== wd_m || both_cnt != 0) begin
        errors++; $display("FAIL rnd%0d_regs got %h/%h both=%0d exp %h/%h", f, address, wr_data,
                           both_cnt, addr_m, wd_m);
      end
      if (e.n_wr == 1 && wr_log.size() == 1) begin
        checks++;
        if (wr_log[0] !== {addr_m, wd_m}) begin
          errors++; $display("FAIL rnd%0d_wr got %h exp %h", f, wr_log[0], {addr_m, wd_m});
        end
      end
      if (cmd[7] && nbits == 16) begin
        for (int k = 0; k < 8; k++) got[7-k] = miso_seen[8+k];
        checks++;
        if (got !== rd_resp || miso_seen[7:0] !== 8'h0) begin
          errors++; $display("FAIL rnd%0d_miso got %h exp %h", f, got, rd_resp);
        end
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    spi_sclk = 1'b0;
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    rd_resp = 8'h00;
    rd_hold = 1'b0;
    addr_m = 6'h0;
    wd_m = 8'h0;
    err_cnt = 0;
    both_cnt = 0;
    miso_seen = '0;
    test_reset();
    test_write();
    test_read();
    test_abort();
    test_abort_on_16th();
    test_reset_mid_frame();
    test_extra_sclk();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
